// File: rtl/q88_pkg.sv
`default_nettype none
// =============================================================================
//  Module   : q88_pkg
//  Purpose  : Shared Q8.8 constants, word type and MAC state encoding.
//  Revision : 1.0
// =============================================================================
package q88_pkg;

    localparam int          Q88_FRAC = 8;
    localparam logic [15:0] Q88_MAX  = 16'h7FFF;
    localparam logic [15:0] Q88_MIN  = 16'h8000;

    typedef logic signed [15:0] q88_t;

    typedef enum logic [1:0] {
        ACCUM  = 2'd0,
        FINISH = 2'd1,
        OUTPUT = 2'd2
    } mac_state_e;

endpackage
`default_nettype wire

// File: rtl/q88_neuron_mac_if.sv
`default_nettype none
// =============================================================================
//  Module   : q88_neuron_mac_if
//  Purpose  : Input-beat and result handshake bundle for the Q8.8 neuron MAC.
//  Revision : 1.0
// =============================================================================
interface q88_neuron_mac_if;

    logic        in_valid;
    logic        in_ready;
    logic [15:0] x_in;
    logic [15:0] w_in;
    logic [15:0] bias_in;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] z_out;
    logic        out_sat;
    logic        out_overrun;

    modport master (
        output in_valid, x_in, w_in, bias_in, in_last, out_ready,
        input  in_ready, out_valid, z_out, out_sat, out_overrun
    );

    modport slave (
        input  in_valid, x_in, w_in, bias_in, in_last, out_ready,
        output in_ready, out_valid, z_out, out_sat, out_overrun
    );

endinterface
`default_nettype wire

// File: rtl/q88_round_sat.sv
`default_nettype none
// =============================================================================
//  Module   : q88_round_sat
//  Purpose  : Round-half-up and saturate a wide signed accumulator to Q8.8.
//  Revision : 1.0
// =============================================================================
module q88_round_sat
    import q88_pkg::*;
#(
    parameter int ACC_W = 40,
    parameter int FRAC  = Q88_FRAC
) (
    input  wire logic signed [ACC_W-1:0] acc_in,
    output q88_t                         z_out,
    output logic                         sat_out
);

    localparam logic signed [ACC_W-1:0] C_HALF = ACC_W'(2 ** (FRAC - 1));
    localparam logic signed [ACC_W-1:0] C_HI   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] C_LO   = -ACC_W'(32768);

    logic signed [ACC_W-1:0] w_r;
    logic signed [ACC_W-1:0] w_q;

    always_comb begin
        w_r     = acc_in + C_HALF;
        w_q     = w_r >>> FRAC;
        z_out   = w_q[15:0];
        sat_out = 1'b0;
        if (w_q > C_HI) begin
            z_out   = Q88_MAX;
            sat_out = 1'b1;
        end else if (w_q < C_LO) begin
            z_out   = Q88_MIN;
            sat_out = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/q88_neuron_mac.sv
`default_nettype none
// =============================================================================
//  Module   : q88_neuron_mac
//  Purpose  : Streaming Q8.8 dot product plus bias, rounded/saturated to Q8.8.
//  Revision : 1.0
// =============================================================================
module q88_neuron_mac
    import q88_pkg::*;
#(
    parameter int N_MAX = 16,
    parameter int ACC_W = 40,
    parameter int FRAC  = Q88_FRAC
) (
    input  wire logic          clk,
    input  wire logic          rst,
    q88_neuron_mac_if.slave    bus
);

    localparam int CNT_W = (N_MAX > 1) ? $clog2(N_MAX) : 1;

    mac_state_e              state_q,     state_d;
    logic [CNT_W-1:0]        count_q,     count_d;
    logic                    first_q,     first_d;
    logic                    ovr_tag_q,   ovr_tag_d;
    q88_t                    bias_q,      bias_d;
    logic signed [31:0]      prod_q,      prod_d;
    logic                    pvld_q,      pvld_d;
    logic                    pfirst_q,    pfirst_d;
    logic signed [ACC_W-1:0] acc_q,       acc_d;
    logic                    out_valid_q, out_valid_d;
    logic [15:0]             z_q,         z_d;
    logic                    sat_q,       sat_d;
    logic                    ovr_q,       ovr_d;

    logic                    w_accept;
    logic                    w_last_eff;
    logic signed [31:0]      w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic signed [ACC_W-1:0] w_bias_ext;
    q88_t                    w_z;
    logic                    w_sat;

    q88_round_sat #(.ACC_W(ACC_W), .FRAC(FRAC)) u_round_sat (
        .acc_in  (acc_q),
        .z_out   (w_z),
        .sat_out (w_sat)
    );

    assign w_accept   = bus.in_valid & (state_q == ACCUM);
    assign w_last_eff = bus.in_last | (count_q == CNT_W'(N_MAX - 1));
    assign w_prod     = $signed(bus.x_in) * $signed(bus.w_in);
    assign w_prod_ext = {{(ACC_W-32){prod_q[31]}}, prod_q};
    assign w_bias_ext = {{(ACC_W-16-FRAC){bias_q[15]}}, bias_q, {FRAC{1'b0}}};

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        first_d     = first_q;
        ovr_tag_d   = ovr_tag_q;
        bias_d      = bias_q;
        prod_d      = prod_q;
        pvld_d      = w_accept;
        pfirst_d    = pfirst_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        z_d         = z_q;
        sat_d       = sat_q;
        ovr_d       = ovr_q;

        // Stage 1: register the product; bias is only taken from the opening beat.
        if (w_accept) begin
            prod_d   = w_prod;
            pfirst_d = first_q;
            if (first_q) begin
                bias_d = bus.bias_in;
            end
            if (w_last_eff) begin
                count_d   = '0;
                first_d   = 1'b1;
                ovr_tag_d = ~bus.in_last;
                state_d   = FINISH;
            end else begin
                count_d = count_q + 1'b1;
                first_d = 1'b0;
            end
        end

        if (pvld_q) begin
            acc_d = pfirst_q ? (w_bias_ext + w_prod_ext) : (acc_q + w_prod_ext);
        end

        case (state_q)
            FINISH: state_d = OUTPUT;
            OUTPUT: begin
                // First OUTPUT cycle captures the finalised accumulator.
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                    z_d         = w_z;
                    sat_d       = w_sat;
                    ovr_d       = ovr_tag_q;
                end else if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ACCUM;
                    count_d     = '0;
                    first_d     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ACCUM;
            count_q     <= '0;
            first_q     <= 1'b1;
            ovr_tag_q   <= 1'b0;
            bias_q      <= '0;
            prod_q      <= '0;
            pvld_q      <= 1'b0;
            pfirst_q    <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            z_q         <= '0;
            sat_q       <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            first_q     <= first_d;
            ovr_tag_q   <= ovr_tag_d;
            bias_q      <= bias_d;
            prod_q      <= prod_d;
            pvld_q      <= pvld_d;
            pfirst_q    <= pfirst_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            z_q         <= z_d;
            sat_q       <= sat_d;
            ovr_q       <= ovr_d;
        end
    end

    assign bus.in_ready    = (state_q == ACCUM);
    assign bus.out_valid   = out_valid_q;
    assign bus.z_out       = z_q;
    assign bus.out_sat     = sat_q;
    assign bus.out_overrun = ovr_q;

endmodule
`default_nettype wire
